div_16_8: RTL and testbench



---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 31 +++
 rtl/div_16_8.sv | 163 ++++++++++++++++
 tb/tb_div_16_8.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider div_16_8.
//   div_state_e  : controller states (IDLE / RUN / FIN)
//   DIV_DVD_W    : default dividend / quotient width
//   DIV_DVS_W    : default divisor / remainder width
//   DIV_CNT_W    : iteration counter width
//   DIV_DZ_QUOT  : quotient reported on divide-by-zero
//   DIV_DZ_FLAG  : value of the dz flag on divide-by-zero
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_e;

  localparam int DIV_DVD_W = 16;
  localparam int DIV_DVS_W = 8;
  localparam int DIV_CNT_W = $clog2(DIV_DVD_W);

  localparam logic [DIV_DVD_W-1:0] DIV_DZ_QUOT = '1;
  localparam logic                 DIV_DZ_FLAG = 1'b1;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   rem_i   : current partial remainder (W+1 bits, always < divisor)
//   bit_i   : next dividend bit, shifted in at the LSB
//   dvs_i   : divisor
//   rem_o   : next partial remainder
//   qbit_o  : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  // One spare MSB so a negative trial difference shows up as a borrow bit.
  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, dvs_i};
    qbit_o  = ~diff[W+1];
    rem_o   = qbit_o ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/div_16_8.sv
// -----------------------------------------------------------------------------
// div_16_8
// Sequential restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : dividend / divisor, captured on an accepted start
//   busy  : high while iterating
//   done  : one-cycle pulse, q/r/dz valid from this cycle on
//   q, r  : quotient / remainder
//   dz    : divide-by-zero flag for the last operation
// Optional build macro DIV_SIGNED_EN: two's-complement operands; magnitudes
// are divided by the unsigned core and signs are fixed up when results commit.
// -----------------------------------------------------------------------------
module div_16_8
  import div_pkg::*;
#(
  parameter int DVD_W = DIV_DVD_W,
  parameter int DVS_W = DIV_DVS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] a,
  input  logic [DVS_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] q,
  output logic [DVS_W-1:0] r,
  output logic             dz
);

  localparam int CNT_W = DIV_CNT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVD_W - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W:0]   rem_q;
  // Holds the dividend during RUN; quotient bits fill in from the LSB as
  // dividend bits leave at the MSB, so after the last step it is the quotient.
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic             dz_pend_q;
  logic             busy_q;
  logic             done_q;
  logic [DVD_W-1:0] q_q;
  logic [DVS_W-1:0] r_q;
  logic             dz_q;

  logic [DVD_W-1:0] a_mag;
  logic [DVS_W-1:0] b_mag;
  logic [DVD_W-1:0] q_fix;
  logic [DVS_W-1:0] r_fix;
  logic [DVS_W:0]   step_rem_d;
  logic             step_qbit;

`ifdef DIV_SIGNED_EN
  logic a_neg_q;
  logic b_neg_q;

  always_comb begin
    a_mag = a[DVD_W-1] ? -a : a;
    b_mag = b[DVS_W-1] ? -b : b;
    // Truncation toward zero; the remainder follows the dividend's sign.
    q_fix = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
    r_fix = a_neg_q ? -rem_q[DVS_W-1:0] : rem_q[DVS_W-1:0];
  end
`else
  always_comb begin
    a_mag = a;
    b_mag = b;
    q_fix = dvd_q;
    r_fix = rem_q[DVS_W-1:0];
  end
`endif

  div_step #(
    .W (DVS_W)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[DVD_W-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem_d),
    .qbit_o (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      dz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            rem_q <= '0;
            dvs_q <= b_mag;
`ifdef DIV_SIGNED_EN
            a_neg_q <= a[DVD_W-1];
            b_neg_q <= b[DVS_W-1];
`endif
            if (b == '0) begin
              // Raw dividend is kept so its low bits can be reported as r.
              dvd_q     <= a;
              dz_pend_q <= 1'b1;
              state_q   <= ST_FIN;
            end else begin
              dvd_q     <= a_mag;
              dz_pend_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          dvd_q <= {dvd_q[DVD_W-2:0], step_qbit};
          rem_q <= step_rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          // Result commit cycle: outputs and done are visible from the next cycle.
          done_q <= 1'b1;
          if (dz_pend_q) begin
            q_q  <= DVD_W'(DIV_DZ_QUOT);
            r_q  <= dvd_q[DVS_W-1:0];
            dz_q <= DIV_DZ_FLAG;
          end else begin
            q_q  <= q_fix;
            r_q  <= r_fix;
            dz_q <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_div_16_8.sv
module tb_div_16_8;

  localparam int LAT_RUN = 17;
  localparam int LAT_DZ  = 1;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;

  int n_cmp = 0;
  int n_err = 0;

  div_16_8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] av, input logic [7:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; 0 means timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (done) lat = i;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.a, v.b);
    chk({tag, "_busy_run"}, {31'd0, busy}, {31'd0, (v.b != 8'd0)});
    wait_done(lat);
    chk({tag, "_lat"}, lat, (v.b != 8'd0) ? LAT_RUN : LAT_DZ);
    chk({tag, "_q"}, {16'd0, q}, {16'd0, v.q});
    chk({tag, "_r"}, {24'd0, r}, {24'd0, v.r});
    chk({tag, "_dz"}, {31'd0, dz}, {31'd0, v.dz});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    $display("op %s a=%04h b=%02h -> q=%04h r=%02h dz=%0b lat=%0d", tag, v.a, v.b, q, r, dz, lat);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   lat;
    int   n;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0});  // -100 / 7
    vecs.push_back('{16'd100,  8'hF9, 16'hFFF2, 8'h02, 1'b0});  // 100 / -7
    vecs.push_back('{16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0});  // -32768 / -1
    vecs.push_back('{16'd50,   8'h00, 16'hFFFF, 8'd50, 1'b1});
    vecs.push_back('{16'd9,    8'd3,  16'd3,    8'd0,  1'b0});
`else
    vecs.push_back('{16'd1000,  8'd50,  16'd20,    8'd0,  1'b0});
    vecs.push_back('{16'd100,   8'd7,   16'd14,    8'd2,  1'b0});
    vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0});
    vecs.push_back('{16'd17,    8'd255, 16'd0,     8'd17, 1'b0});
    vecs.push_back('{16'd50,    8'd0,   16'hFFFF,  8'd50, 1'b1});
    vecs.push_back('{16'd9,     8'd3,   16'd3,     8'd0,  1'b0});
    vecs.push_back('{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0});
    vecs.push_back('{16'd12345, 8'd100, 16'd123,   8'd45, 1'b0});
`endif

    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_outs", {8'd0, busy, done, dz, q, r}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Second start during RUN is ignored; input changes after capture too.
    start_op(16'd6500, 8'd10);
    repeat (4) @(posedge clk);
    start_op(16'd1, 8'd1);
    wait_done(lat);
    chk("ign_lat", lat, LAT_RUN - 5);
    chk("ign_q", {16'd0, q}, 32'd650);
    chk("ign_r", {24'd0, r}, 32'd0);
    $display("op ignored-start a=6500 b=10 -> q=%0d r=%0d lat=%0d", q, r, lat);
    count_dones(25, n);
    chk("ign_no_requeue", n, 0);

    // Asynchronous reset between edges during cycle 8 of an operation.
    start_op(16'd1000, 8'd50);
    repeat (7) @(posedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_outs", {8'd0, busy, done, dz, q, r}, 32'd0);
    $display("op abort: busy=%0b done=%0b q=%0h r=%0h dz=%0b", busy, done, q, r, dz);
    @(negedge clk);
    rst = 1'b0;
    count_dones(25, n);
    chk("abort_no_done", n, 0);

    v = '{16'd9, 8'd3, 16'd3, 8'd0, 1'b0};
    run_vec(v, "post_rst");

    // Results hold while inputs wander and no start is given.
    @(negedge clk);
    a = 16'hBEEF;
    b = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_q", {16'd0, q}, 32'd3);
    chk("hold_dz", {31'd0, dz}, 32'd0);
    $display("op hold: q=%0d r=%0d dz=%0b", q, r, dz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
